// File: rtl/vga_grid_scanner.sv
// 640x480@60 VGA timing generator that scans a COLSxROWS grid of 3-bit cell codes
// into RGB444, with a two-tick registered pipeline from pixel counters to outputs.

module vga_grid_scanner #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          COLS      = 10,
    parameter int          ROWS      = 20,
    parameter int          CELL_PX   = 20,
    parameter int          GRID_X0   = 220,
    parameter int          GRID_Y0   = 40,
    parameter logic [11:0] GRID_LINE = 12'h222
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_ce,
    input  logic [3*COLS*ROWS-1:0] frame_in,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [11:0]            rgb,
    output logic                   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CXW     = $clog2(COLS + 1);
    localparam int CYW     = $clog2(ROWS + 1);
    localparam int SW      = $clog2(CELL_PX + 1);
    localparam int IW      = $clog2(3 * COLS * ROWS);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] GX_BEG  = HW'(GRID_X0);
    localparam logic [HW-1:0] GX_END  = HW'(GRID_X0 + COLS * CELL_PX);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] GY_BEG  = VW'(GRID_Y0);
    localparam logic [VW-1:0] GY_END  = VW'(GRID_Y0 + ROWS * CELL_PX);
    localparam logic [SW-1:0] SUB_LAST = SW'(CELL_PX - 1);

    logic [HW-1:0]  hCount_q, hCount_d;
    logic [VW-1:0]  vCount_q, vCount_d;
    logic [SW-1:0]  subX_q, subX_d, subY_q, subY_d;
    logic [CXW-1:0] cellX_q, cellX_d;
    logic [CYW-1:0] cellY_q, cellY_d;
    logic           hWrap, vWrap;
    logic [HW-1:0]  hNext;
    logic [VW-1:0]  vNext;

    logic           hsyncS1_q, hsyncS1_d;
    logic           vsyncS1_q, vsyncS1_d;
    logic           deS1_q, deS1_d;
    logic           gridS1_q, gridS1_d;
    logic [2:0]     codeS1_q, codeS1_d;
    logic           lineS1_q, lineS1_d;
    logic           startS1_q, startS1_d;
    logic [IW-1:0]  cellIdx;

    logic           hsync_q, vsync_q, de_q, frameStart_q;
    logic [11:0]    rgb_q, rgb_d;

    // Cell and sub-cell counters are loaded one tick ahead from the next pixel
    // position, so they always describe the pixel currently held in the counters.
    always_comb begin
        hWrap    = (hCount_q == H_LAST);
        vWrap    = (vCount_q == V_LAST);
        hNext    = hWrap ? '0 : hCount_q + HW'(1);
        vNext    = hWrap ? (vWrap ? '0 : vCount_q + VW'(1)) : vCount_q;
        hCount_d = hNext;
        vCount_d = vNext;
        subX_d   = subX_q;
        cellX_d  = cellX_q;
        subY_d   = subY_q;
        cellY_d  = cellY_q;
        if (hNext == GX_BEG) begin
            subX_d  = '0;
            cellX_d = '0;
        end else if ((hNext > GX_BEG) && (hNext < GX_END)) begin
            if (subX_q == SUB_LAST) begin
                subX_d  = '0;
                cellX_d = cellX_q + CXW'(1);
            end else begin
                subX_d  = subX_q + SW'(1);
            end
        end
        if (hWrap) begin
            if (vNext == GY_BEG) begin
                subY_d  = '0;
                cellY_d = '0;
            end else if ((vNext > GY_BEG) && (vNext < GY_END)) begin
                if (subY_q == SUB_LAST) begin
                    subY_d  = '0;
                    cellY_d = cellY_q + CYW'(1);
                end else begin
                    subY_d  = subY_q + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hCount_q <= '0;
            vCount_q <= '0;
            subX_q   <= '0;
            subY_q   <= '0;
            cellX_q  <= '0;
            cellY_q  <= '0;
        end else if (pix_ce) begin
            hCount_q <= hCount_d;
            vCount_q <= vCount_d;
            subX_q   <= subX_d;
            subY_q   <= subY_d;
            cellX_q  <= cellX_d;
            cellY_q  <= cellY_d;
        end
    end

    // Stage 1: sync/active decode and the cell code lookup. The cell counters stay
    // within the grid outside the region, so the index is always in range.
    always_comb begin
        cellIdx   = IW'(3 * (32'(cellX_q) * ROWS + 32'(cellY_q)));
        hsyncS1_d = !((hCount_q >= HS_BEG) && (hCount_q < HS_END));
        vsyncS1_d = !((vCount_q >= VS_BEG) && (vCount_q < VS_END));
        deS1_d    = (hCount_q < H_ACT) && (vCount_q < V_ACT);
        gridS1_d  = (hCount_q >= GX_BEG) && (hCount_q < GX_END) &&
                    (vCount_q >= GY_BEG) && (vCount_q < GY_END);
        codeS1_d  = frame_in[cellIdx +: 3];
        lineS1_d  = (subX_q == '0) || (subY_q == '0);
        startS1_d = (hCount_q == '0) && (vCount_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsyncS1_q <= 1'b1;
            vsyncS1_q <= 1'b1;
            deS1_q    <= 1'b0;
            gridS1_q  <= 1'b0;
            codeS1_q  <= 3'b000;
            lineS1_q  <= 1'b0;
            startS1_q <= 1'b0;
        end else if (pix_ce) begin
            hsyncS1_q <= hsyncS1_d;
            vsyncS1_q <= vsyncS1_d;
            deS1_q    <= deS1_d;
            gridS1_q  <= gridS1_d;
            codeS1_q  <= codeS1_d;
            lineS1_q  <= lineS1_d;
            startS1_q <= startS1_d;
        end
    end

    // Stage 2: empty cells show only their top/left edge in the grid-line colour.
    always_comb begin
        rgb_d = 12'h000;
        if (deS1_q && gridS1_q) begin
            if (codeS1_q != 3'b000) begin
                rgb_d = {{4{codeS1_q[2]}}, {4{codeS1_q[1]}}, {4{codeS1_q[0]}}};
            end else if (lineS1_q) begin
                rgb_d = GRID_LINE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            de_q         <= 1'b0;
            rgb_q        <= 12'h000;
            frameStart_q <= 1'b0;
        end else if (pix_ce) begin
            hsync_q      <= hsyncS1_q;
            vsync_q      <= vsyncS1_q;
            de_q         <= deS1_q;
            rgb_q        <= rgb_d;
            frameStart_q <= startS1_q;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign frame_start = frameStart_q;

endmodule
